star_scheduler: RTL
===================

# star_scheduler

Central controller for the level's collectible stars. It holds a configurable table of up to NUM_STARS star world positions. Once per video frame it scans the table, time-sharing one overlap comparator across all stars. When the character touches an enabled star, the block retires that star, bumps the score and emits a collection event. It sits between the character-position logic and the renderer/score display and replaces per-star collision instances.

## Interface
- NUM_STARS, 8, number of star slots (2..16); index width IW = clog2(NUM_STARS)
- STAR_SIZE, 12, star bounding-box extent in pixels
- CHAR_SIZE, 12, character bounding-box extent in pixels

Ports:
- sys_clk  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle pulse, starts a scan
- restart  in  1  sync pulse: re-enable all loaded stars, clear score
- char_X  in  10  character world X
- char_Y  in  10  character world Y
- bg_pos  in  10  background scroll offset
- cfg_we  in  1  table write strobe
- cfg_idx  in  IW  slot to write
- cfg_x  in  10  star world X
- cfg_y  in  10  star world Y
- rd_idx  in  IW  renderer read slot
- rd_x  out  10  screen X of slot rd_idx (world X − bg_pos)
- rd_y  out  10  Y of slot rd_idx
- rd_en  out  1  slot rd_idx enabled (visible)
- star_en  out  NUM_STARS  per-slot enable mask
- collect_pulse  out  1  one-cycle pulse, star collected
- collect_idx  out  IW  slot collected (valid with collect_pulse)
- score  out  8  collected count, saturates at 255
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at scan end
- all_collected  out  1  loaded mask ≠ 0 and no loaded slot enabled

## Operation
- Table per slot: x[9:0], y[9:0], loaded, enable. Reset value of each field is 0.
- Config write (cfg_we): sets x, y, loaded=1 and enable=1 for cfg_idx. Accepted in any state.
- Overlap test, all sums 10-bit wrap:
  - ovX = (cx ≥ sx ∧ cx ≤ sx+STAR_SIZE) ∨ (cx+CHAR_SIZE ≥ sx ∧ cx+CHAR_SIZE ≤ sx+STAR_SIZE)
  - ovY is the same test using the Y coordinates.
  - A hit requires enable ∧ ovX ∧ ovY.
- FSM:
  - IDLE: on frame_tick, latch char_X/char_Y into cx/cy, set idx=0 → SCAN.
  - SCAN: evaluate slot idx once per cycle. On a hit: clear enable[idx], score += 1 (saturating), register collect_pulse/collect_idx. When idx = NUM_STARS−1 → DONE, else idx+1.
  - DONE: scan_done=1 for one cycle → IDLE.
- frame_tick outside IDLE is ignored; it is not queued.
- restart: enable ← loaded, score ← 0, FSM ← IDLE, collect_pulse suppressed. Takes priority over a hit in the same cycle.
- A cfg write to the slot being evaluated in the same cycle wins: the slot ends enabled, with no collection and no score change.
- Read port is combinational from the table: rd_x = x[rd_idx] − bg_pos (10-bit wrap), rd_y = y[rd_idx], rd_en = enable[rd_idx].

## Timing
- Reset outputs: star_en=0, score=0, collect_pulse=0, collect_idx=0, scan_busy=0, scan_done=0, all_collected=0. Read outputs reflect zeroed table (rd_x = −bg_pos).
- frame_tick in cycle T:
  - scan_busy is high from T+1 through T+NUM_STARS.
  - Slot i is evaluated in cycle T+1+i.
  - collect_pulse for slot i appears in cycle T+2+i, with star_en[i]=0 and the updated score in the same cycle.
  - scan_done is high in cycle T+NUM_STARS+1; scan_busy is low in that cycle.
- Scan period is NUM_STARS+1 cycles. The next frame_tick is accepted in cycle T+NUM_STARS+2 or later.
- cx/cy are frozen for the whole scan; char_X changes mid-scan are not seen until the next frame.
- A collected star stays disabled until restart or a cfg write to that slot. It never produces a second pulse.
- Score holds at 255; further collections still pulse.
- Asynchronous reset mid-scan returns to IDLE with all outputs at their reset values. The table is cleared.

## Test plan
- Config slot 2 = (100,80), char (104,84), frame_tick at T → collect_pulse at T+4 with collect_idx=2, score=1, star_en[2]=0, scan_done at T+9.
- Same position, second frame_tick → no collect_pulse, score stays 1.
- Char (200,200), all 8 slots loaded elsewhere → scan_busy high for 8 cycles, scan_done pulse, no collections, star_en=0xFF.
- Slots 0 and 7 both at char position → pulses at T+2 (idx 0) and T+9 (idx 7), score=2. With slots 0 and 7 as the only loaded slots, all_collected=1.
- restart after collections → star_en = loaded mask, score=0. cfg_we to slot 3 during slot 3's evaluation cycle → slot 3 stays enabled, no pulse.
- bg_pos=30, slot 1 x=20 → rd_x=1014 (wrap). RST_N low mid-scan → busy=0, score=0, star_en=0 immediately.

Source files
------------

// File: rtl/star_scheduler_if.sv
// Bus bundle for star_scheduler: frame control, character position, star table
// configuration, renderer read port and collection/status outputs.
interface star_scheduler_if #(
   parameter int unsigned NUM_STARS = 8
);
   localparam int unsigned IW = $clog2(NUM_STARS);

   logic                 frame_tick;
   logic                 restart;
   logic [9:0]           char_X;
   logic [9:0]           char_Y;
   logic [9:0]           bg_pos;
   logic                 cfg_we;
   logic [IW-1:0]        cfg_idx;
   logic [9:0]           cfg_x;
   logic [9:0]           cfg_y;
   logic [IW-1:0]        rd_idx;
   logic [9:0]           rd_x;
   logic [9:0]           rd_y;
   logic                 rd_en;
   logic [NUM_STARS-1:0] star_en;
   logic                 collect_pulse;
   logic [IW-1:0]        collect_idx;
   logic [7:0]           score;
   logic                 scan_busy;
   logic                 scan_done;
   logic                 all_collected;

   modport slave (
      input  frame_tick, restart, char_X, char_Y, bg_pos,
      input  cfg_we, cfg_idx, cfg_x, cfg_y, rd_idx,
      output rd_x, rd_y, rd_en, star_en, collect_pulse, collect_idx,
      output score, scan_busy, scan_done, all_collected
   );

   modport master (
      output frame_tick, restart, char_X, char_Y, bg_pos,
      output cfg_we, cfg_idx, cfg_x, cfg_y, rd_idx,
      input  rd_x, rd_y, rd_en, star_en, collect_pulse, collect_idx,
      input  score, scan_busy, scan_done, all_collected
   );
endinterface

// File: rtl/star_scheduler.sv
// Star table with a once-per-frame scan that shares one overlap comparator across
// all slots, retiring touched stars and keeping a saturating score.
module star_scheduler #(
   parameter int unsigned NUM_STARS = 8,
   parameter int unsigned STAR_SIZE = 12,
   parameter int unsigned CHAR_SIZE = 12
) (
   input logic             sys_clk,
   input logic             RST_N,
   star_scheduler_if.slave bus
);
   localparam int unsigned   IW      = $clog2(NUM_STARS);
   localparam logic [IW-1:0] LastIdx = IW'(NUM_STARS - 1);
   localparam logic [9:0]    StarSz  = 10'(STAR_SIZE);
   localparam logic [9:0]    CharSz  = 10'(CHAR_SIZE);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [9:0]           cx_q, cx_d;
   logic [9:0]           cy_q, cy_d;
   logic [9:0]           x_q [NUM_STARS];
   logic [9:0]           y_q [NUM_STARS];
   logic [NUM_STARS-1:0] loaded_q;
   logic [NUM_STARS-1:0] en_q;
   logic [7:0]           score_q;
   logic                 pulse_q;
   logic [IW-1:0]        cidx_q;
   logic                 ov_x, ov_y, cfg_same, hit;

   // All sums wrap at 10 bits, matching the screen coordinate space.
   function automatic logic overlap(input logic [9:0] c, input logic [9:0] s);
      logic [9:0] s_end;
      logic [9:0] c_end;
      s_end = s + StarSz;
      c_end = c + CharSz;
      return ((c >= s) && (c <= s_end)) || ((c_end >= s) && (c_end <= s_end));
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      unique case (state_q)
         StIdle: begin
            if (bus.frame_tick) begin
               cx_d    = bus.char_X;
               cy_d    = bus.char_Y;
               idx_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (idx_q == LastIdx) state_d = StDone;
            else                  idx_d   = idx_q + 1'b1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (bus.restart) state_d = StIdle;
   end

   // A same-cycle config write or restart on the evaluated slot overrides the hit.
   always_comb begin
      ov_x     = overlap(cx_q, x_q[idx_q]);
      ov_y     = overlap(cy_q, y_q[idx_q]);
      cfg_same = bus.cfg_we && (bus.cfg_idx == idx_q);
      hit      = (state_q == StScan) && en_q[idx_q] && ov_x && ov_y &&
                 !bus.restart && !cfg_same;
   end

   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
      end
   end

   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < NUM_STARS; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
         loaded_q <= '0;
         en_q     <= '0;
         score_q  <= '0;
         pulse_q  <= 1'b0;
         cidx_q   <= '0;
      end else begin
         if (bus.restart) begin
            en_q    <= loaded_q;
            score_q <= '0;
         end else if (hit) begin
            en_q[idx_q] <= 1'b0;
            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
         end
         if (bus.cfg_we) begin
            x_q[bus.cfg_idx]      <= bus.cfg_x;
            y_q[bus.cfg_idx]      <= bus.cfg_y;
            loaded_q[bus.cfg_idx] <= 1'b1;
            en_q[bus.cfg_idx]     <= 1'b1;
         end
         pulse_q <= hit;
         if (hit) cidx_q <= idx_q;
      end
   end

   assign bus.rd_x          = x_q[bus.rd_idx] - bus.bg_pos;
   assign bus.rd_y          = y_q[bus.rd_idx];
   assign bus.rd_en         = en_q[bus.rd_idx];
   assign bus.star_en       = en_q;
   assign bus.collect_pulse = pulse_q;
   assign bus.collect_idx   = cidx_q;
   assign bus.score         = score_q;
   assign bus.scan_busy     = (state_q == StScan);
   assign bus.scan_done     = (state_q == StDone);
   assign bus.all_collected = (|loaded_q) && !(|(loaded_q & en_q));
endmodule
